// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, reset/NOP defaults and the
// opcode values that decode matches against instr[6:0].
package cpu_pkg;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      HOLD  = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   function automatic logic [6:0] opcode_of(input logic [31:0] word);
      return word[6:0];
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC candidates for the fetch unit: sequential pc + 4, and the effective
// redirect target (live redirect wins over a parked one) with its alignment check.
module next_pc_sel (
   input  logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic [31:0] pending_target,
   output logic [31:0] seq_pc,
   output logic [31:0] target,
   output logic        misaligned
);

   always_comb begin
      seq_pc     = pc + 32'd4;
      target     = redirect_valid ? redirect_target : pending_target;
      misaligned = |target[1:0];
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack bus and hands
// instructions to decode with valid/ready; redirects and misaligned targets handled here.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] NOP_INSTR    = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_ack,
   input  logic [31:0] ibus_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        fault,
   output logic [31:0] fault_addr
);

   fetch_state_e state, state_d;
   logic [31:0]  pc, pc_d;
   logic [31:0]  pending_target, pending_target_d;
   logic [31:0]  instr_q, instr_q_d;
   logic [31:0]  instr_pc_d, fault_addr_d;
   logic         kill, kill_d;
   logic         running;
   logic [31:0]  seq_pc, target;
   logic         misaligned;
   logic         xfer;

   next_pc_sel u_next_pc_sel (
      .pc              (pc),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .pending_target  (pending_target),
      .seq_pc          (seq_pc),
      .target          (target),
      .misaligned      (misaligned)
   );

   // running holds the request off for the single edge after reset release.
   assign ibus_req    = running && (state == REQ);
   assign ibus_addr   = pc;
   assign instr_valid = (state == HOLD);
   assign instr       = instr_valid ? instr_q : NOP_INSTR;
   assign fault       = (state == FAULT);
   assign xfer        = ibus_req && ibus_ack;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d          = state;
      pc_d             = pc;
      kill_d           = kill;
      pending_target_d = pending_target;
      instr_q_d        = instr_q;
      instr_pc_d       = instr_pc;
      fault_addr_d     = fault_addr;

      unique case (state)
         REQ: begin
            if (xfer) begin
               if (kill || redirect_valid) begin
                  kill_d = 1'b0;
                  if (misaligned) begin
                     state_d      = FAULT;
                     fault_addr_d = target;
                  end else begin
                     pc_d = target;
                  end
               end else begin
                  instr_q_d  = ibus_rdata;
                  instr_pc_d = pc;
                  state_d    = HOLD;
               end
            end else if (redirect_valid) begin
               // Address must stay stable until ack, so park the target; last one wins.
               pending_target_d = redirect_target;
               kill_d           = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               instr_q_d = NOP_INSTR;
               if (misaligned) begin
                  state_d      = FAULT;
                  fault_addr_d = target;
               end else begin
                  pc_d    = target;
                  state_d = REQ;
               end
            end else if (instr_ready) begin
               instr_q_d = NOP_INSTR;
               pc_d      = seq_pc;
               state_d   = REQ;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = FAULT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= REQ;
         pc             <= RESET_VECTOR;
         running        <= 1'b0;
         kill           <= 1'b0;
         pending_target <= 32'd0;
         instr_q        <= NOP_INSTR;
         instr_pc       <= RESET_VECTOR;
         fault_addr     <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state          <= state_d;
         pc             <= pc_d;
         running        <= 1'b1;
         kill           <= kill_d;
         pending_target <= pending_target_d;
         instr_q        <= instr_q_d;
         instr_pc       <= instr_pc_d;
         fault_addr     <= fault_addr_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bus slave driven inline, expected fetches
// queued at transfer time and popped when decode sees them.
module tb_fetch_unit;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } fetch_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ack;
   logic [31:0] ibus_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        fault;
   logic [31:0] fault_addr;

   fetch_t sb[$];
   int     total  = 0;
   int     passed = 0;
   bit     use_fixed = 1'b1;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_unit dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .ibus_req        (ibus_req),
      .ibus_addr       (ibus_addr),
      .ibus_ack        (ibus_ack),
      .ibus_rdata      (ibus_rdata),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .fault           (fault),
      .fault_addr      (fault_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return use_fixed ? 32'h0050_0093 : (a ^ 32'h0A5A_0013);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive one cycle of inputs, let the edge happen, return 1 time unit after it.
   task automatic step(input logic ack, input logic rdy, input logic rv, input logic [31:0] rt);
      ibus_ack        = ack;
      instr_ready     = rdy;
      redirect_valid  = rv;
      redirect_target = rt;
      ibus_rdata      = mem_word(ibus_addr);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_req(input string tag, input logic [31:0] addr);
      check({tag, "_req"}, 32'(ibus_req), 32'd1);
      check({tag, "_addr"}, ibus_addr, addr);
   endtask

   task automatic push(input logic [31:0] addr);
      fetch_t e;
      e.word = mem_word(addr);
      e.pc   = addr;
      sb.push_back(e);
   endtask

   task automatic deliver(input string tag);
      fetch_t e;
      check({tag, "_valid"}, 32'(instr_valid), 32'd1);
      if (sb.size() == 0) begin
         total++;
         $error("FAIL %s_sb: observed empty scoreboard required entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, "_instr"}, instr, e.word);
         check({tag, "_pc"}, instr_pc, e.pc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   32'(ibus_req), 32'd0);
      check({tag, "_addr"},  ibus_addr, 32'h0);
      check({tag, "_instr"}, instr, NOP);
      check({tag, "_ipc"},   instr_pc, 32'h0);
      check({tag, "_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_fault"}, 32'(fault), 32'd0);
      check({tag, "_faddr"}, fault_addr, 32'h0);
   endtask

   initial begin
      reset_n = 1'b0; ibus_ack = 1'b0; ibus_rdata = 32'h0;
      instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      reset_n = 1'b1;

      // Zero-wait streaming: REQ/HOLD alternate, addresses 0, 4, 8.
      step(1'b1, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         expect_req($sformatf("seq%0d", k), 32'(k * 4));
         push(32'(k * 4));
         step(1'b1, 1'b1, 1'b0, 32'h0);
         deliver($sformatf("seq%0d", k));
         check($sformatf("seq%0d_hold_req", k), 32'(ibus_req), 32'd0);
         step(1'b1, 1'b1, 1'b0, 32'h0);
         check($sformatf("seq%0d_gap", k), 32'(instr_valid), 32'd0);
      end

      // Decode stall for 5 cycles at 0xC.
      use_fixed = 1'b0;
      expect_req("stall", 32'hC);
      push(32'hC);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         check($sformatf("stall%0d_valid", k), 32'(instr_valid), 32'd1);
         check($sformatf("stall%0d_req", k), 32'(ibus_req), 32'd0);
         check($sformatf("stall%0d_ipc", k), instr_pc, 32'hC);
         check($sformatf("stall%0d_instr", k), instr, 32'hC ^ 32'h0A5A_0013);
      end
      deliver("stall_end");
      step(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect in HOLD at 0x10 (decode not ready) to 0x100; 0x14 never fetched.
      expect_req("hold_redir_pre", 32'h10);
      push(32'h10);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      deliver("hold_redir_at10");
      step(1'b1, 1'b0, 1'b1, 32'h100);
      check("hold_redir_valid", 32'(instr_valid), 32'd0);
      expect_req("hold_redir", 32'h100);
      push(32'h100);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      deliver("fetch100");
      step(1'b1, 1'b1, 1'b1, 32'h20);
      expect_req("to20", 32'h20);

      // Redirect to 0x200 while ack is stalled 3 cycles on 0x20.
      step(1'b0, 1'b1, 1'b1, 32'h200);
      expect_req("kill0", 32'h20);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      expect_req("kill1", 32'h20);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      expect_req("kill2", 32'h20);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("kill_discard_valid", 32'(instr_valid), 32'd0);
      expect_req("kill_new", 32'h200);
      push(32'h200);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      deliver("fetch200");

      // Misaligned redirect from HOLD to 0x102.
      step(1'b1, 1'b1, 1'b1, 32'h102);
      check("mis_fault", 32'(fault), 32'd1);
      check("mis_faddr", fault_addr, 32'h102);
      check("mis_valid", 32'(instr_valid), 32'd0);
      check("mis_instr", instr, NOP);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b1, 1'b1, 32'h300);
         check($sformatf("mis_sticky%0d_req", k), 32'(ibus_req), 32'd0);
         check($sformatf("mis_sticky%0d_fault", k), 32'(fault), 32'd1);
      end
      #2 reset_n = 1'b0;
      #1;
      check("mis_clr_fault", 32'(fault), 32'd0);
      check("mis_clr_faddr", fault_addr, 32'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Misaligned redirect while ack is pending: wait for ack, then fault.
      step(1'b1, 1'b1, 1'b0, 32'h0);
      expect_req("pend_start", 32'h0);
      push(32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      deliver("pend_f0");
      step(1'b1, 1'b1, 1'b0, 32'h0);
      expect_req("pend_at4", 32'h4);
      step(1'b0, 1'b1, 1'b1, 32'h302);
      check("pend_no_fault", 32'(fault), 32'd0);
      expect_req("pend_hold", 32'h4);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("pend_fault", 32'(fault), 32'd1);
      check("pend_faddr", fault_addr, 32'h302);
      check("pend_req", 32'(ibus_req), 32'd0);
      check("pend_valid", 32'(instr_valid), 32'd0);

      // Reset asserted mid-request at 0x40.
      #2 reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 32'h0);
      push(32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      deliver("mid_f0");
      step(1'b1, 1'b1, 1'b1, 32'h40);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      expect_req("mid_at40", 32'h40);
      #2 reset_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      @(posedge clk);
      #1 reset_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 32'h0);
      expect_req("restart", 32'h0);
      push(32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      deliver("restart");

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main decode/control unit.
- Owns the program counter and fetches 32-bit instructions over a req/ack instruction bus.
- Presents the instruction and its PC to decode with a valid/ready handshake; decode takes opcode = instr[6:0].
- Accepts redirects (taken branch, JAL, JALR targets) from the branch/execute logic and flags misaligned fetch targets.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.
- NOP_INSTR, 32'h0000_0013, instruction driven on instr whenever instr_valid is 0 (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ibus_req  out  1  fetch request.
- ibus_addr  out  32  fetch address; word aligned.
- ibus_ack  in  1  request accepted and data returned this cycle.
- ibus_rdata  in  32  instruction word; sampled only when ibus_req && ibus_ack.
- instr  out  32  instruction to decode.
- instr_pc  out  32  address of instr.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  decode consumes instr this cycle; low means stall, e.g. load stall.
- redirect_valid  in  1  control-flow change.
- redirect_target  in  32  new PC.
- fault  out  1  sticky misaligned-fetch fault.
- fault_addr  out  32  offending target.

Behaviour:
- Reset is asynchronous and active-low. While reset_n = 0:
  - state = REQ, pc = RESET_VECTOR
  - ibus_req = 0, ibus_addr = RESET_VECTOR
  - instr = NOP_INSTR, instr_pc = RESET_VECTOR, instr_valid = 0
  - fault = 0, fault_addr = 0
  - kill = 0, pending_target = 0
- First edge after deassertion: ibus_req = 1 with ibus_addr = pc. No idle cycle beyond that edge.
- Bus rules:
  - A transfer completes on a rising edge where ibus_req && ibus_ack. Zero-wait ack in the same cycle as req is legal.
  - ibus_addr is held stable while ibus_req = 1 and ibus_ack = 0.
  - A request, once raised, is never withdrawn before ack.
- State REQ:
  - ibus_req = 1.
  - On ack with kill = 0 and no redirect this cycle: instr <= ibus_rdata, instr_pc <= pc, go to HOLD.
  - On ack with kill = 1 or redirect_valid = 1: discard data, pc <= effective target, kill <= 0, stay in REQ. A new request issues at the new address next cycle.
- State HOLD:
  - ibus_req = 0, instr_valid = 1.
  - On instr_valid && instr_ready, with no redirect: pc <= pc + 4, instr_valid <= 0, instr <= NOP_INSTR, go to REQ.
  - pc wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- State FAULT:
  - ibus_req = 0, instr_valid = 0, fault = 1.
  - Exits only by reset.
- Redirect handling (redirect has priority over sequential increment):
  - In HOLD: the current instruction counts as consumed regardless of instr_ready. instr_valid <= 0, pc <= redirect_target, go to REQ.
  - In REQ without ack: pending_target <= redirect_target, kill <= 1. Repeated redirects before ack overwrite pending_target (last wins).
  - Effective target = redirect_target if redirect_valid is asserted this cycle, else pending_target.
  - Misaligned effective target (bits [1:0] != 0):
    - In HOLD, or in REQ together with ack: go to FAULT, fault_addr <= target.
    - In REQ without ack: wait for the ack, discard its data, then enter FAULT.
    - No bus request is ever issued to a misaligned address.
- Latency:
  - Zero-wait bus: 2 cycles per instruction (REQ, HOLD).
  - Instruction visible to decode on the cycle after ack.
  - Redirect to first new request: 1 cycle.
- Reset asserted mid-transfer: the unit abandons immediately. The bus slave must tolerate a dropped request.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state encoding: REQ = 2'd0, HOLD = 2'd1, FAULT = 2'd2
  - NOP_INSTR constant
  - default RESET_VECTOR
  - opcode constants shared with decode
- One natural sub-module, next_pc_sel: combinational choice among pc + 4, redirect_target and pending_target, plus the alignment check.

Test Plan:
- Reset release, RESET_VECTOR = 0, ack tied 1, ready tied 1, rdata = 0x00500093: ibus_addr sequence 0x0, 0x4, 0x8. instr_valid high every second cycle. First instr = 0x00500093 with instr_pc = 0.
- Decode stall (instr_ready = 0 for 5 cycles) in HOLD: instr, instr_pc and instr_valid hold stable. ibus_req stays 0. No pc increment until ready rises.
- Redirect in HOLD at pc = 0x10 to 0x100: next ibus_addr = 0x100. Instruction at 0x14 is never requested.
- Redirect to 0x200 while ack is stalled 3 cycles on 0x20: ibus_addr stays 0x20 until ack. Data is discarded (instr_valid stays 0). Next request is 0x200.
- Redirect to 0x102: fault = 1 and fault_addr = 0x102 next cycle. ibus_req stays 0 permanently. Clears only on reset_n low.
- Assert reset_n low mid-request at 0x40: outputs take reset values immediately (asynchronous). After release, fetch restarts at RESET_VECTOR.
